// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one uart_tx transmitter among NUM_CH byte-stream requesters.
// Bytes are taken with a valid/ready handshake, picked round-robin in IDLE.
// Each accepted byte is handed to uart_tx as a one-cycle tx_start pulse with
// a latched tx_data. A packet (closed by req_last) keeps ownership of the
// transmitter until its final byte and the inter-frame gap have completed.
//
// Handshake: a byte moves on a cycle where req_valid[i] and req_ready[i]
// are both high. req_ready is combinational, one-hot or zero, and is only
// raised for a channel whose req_valid is already high. A requester keeps
// its data and last flag stable while valid is high and ready is low.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   baud_tick_1x    one-cycle baud tick shared with uart_tx (gap timing)
//   req_valid       per-channel byte valid
//   req_data        channel i byte at [8i+7:8i]
//   req_last        byte is the last of its packet
//   req_ready       one-hot byte accept (combinational)
//   tx_busy         transmitter busy, from uart_tx
//   tx_start        registered one-cycle start pulse to uart_tx
//   tx_data         registered byte to uart_tx
//   grant_valid     a channel currently owns the transmitter
//   grant_id        owning channel
module uart_tx_arbiter #(
    parameter int NUM_CH    = 4,
    parameter int GAP_TICKS = 1,
    parameter int CH_W      = $clog2(NUM_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  baud_tick_1x,
    input  logic [NUM_CH-1:0]     req_valid,
    input  logic [8*NUM_CH-1:0]   req_data,
    input  logic [NUM_CH-1:0]     req_last,
    output logic [NUM_CH-1:0]     req_ready,
    input  logic                  tx_busy,
    output logic                  tx_start,
    output logic [7:0]            tx_data,
    output logic                  grant_valid,
    output logic [CH_W-1:0]       grant_id
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        GAP       = 3'd4,
        HOLD      = 3'd5
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CH_W-1:0] rr_ptr;
    logic [CH_W-1:0] winner;
    logic            winner_found;
    logic [CH_W-1:0] sel;
    logic            accept;
    logic            last_flag;
    logic [7:0]      gap_cnt;
    logic            gap_done;

    // Round-robin search. Offsets are scanned from the far end downward so
    // the last hit written is the one closest to rr_ptr.
    always_comb begin
        logic [CH_W-1:0] idx;
        winner       = rr_ptr;
        winner_found = 1'b0;
        idx          = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = CH_W'((int'(rr_ptr) + i) % NUM_CH);
            if (req_valid[idx]) begin
                winner       = idx;
                winner_found = 1'b1;
            end
        end
    end

    assign gap_done = (gap_cnt == 8'(GAP_TICKS));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE, HOLD: if (accept) state_next = START;
            START:      state_next = WAIT_BUSY;
            WAIT_BUSY:  if (tx_busy) state_next = WAIT_DONE;
            WAIT_DONE:  if (!tx_busy) state_next = GAP;
            GAP:        if (gap_done) state_next = last_flag ? IDLE : HOLD;
            default:    state_next = IDLE;
        endcase
    end

    // Output decode: accept decision and the one-hot ready. In HOLD only the
    // owner is looked at, so other channels wait out the whole packet.
    always_comb begin
        accept    = 1'b0;
        sel       = grant_id;
        req_ready = '0;
        case (state)
            IDLE: begin
                sel    = winner;
                accept = !tx_busy && winner_found;
            end
            HOLD: accept = !tx_busy && req_valid[grant_id];
            default: ;
        endcase
        if (accept) req_ready[sel] = 1'b1;
    end

    // Datapath registers: start pulse, latched byte, ownership, gap count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_start    <= 1'b0;
            tx_data     <= 8'h00;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            last_flag   <= 1'b0;
            rr_ptr      <= '0;
            gap_cnt     <= 8'd0;
        end else begin
            // START always follows an accept by exactly one cycle
            tx_start <= accept;
            if (accept) begin
                tx_data     <= req_data[{sel, 3'b000} +: 8];
                grant_id    <= sel;
                last_flag   <= req_last[sel];
                grant_valid <= 1'b1;
            end
            if (state == GAP && gap_done && last_flag) begin
                grant_valid <= 1'b0;
                rr_ptr      <= (grant_id == CH_W'(NUM_CH - 1)) ? '0 : grant_id + 1'b1;
            end
            // Counter is held clear while the frame is still on the line so
            // ticks are only counted from the cycle after tx_busy falls.
            if (state == WAIT_DONE) begin
                gap_cnt <= 8'd0;
            end else if (state == GAP && !gap_done && baud_tick_1x) begin
                gap_cnt <= gap_cnt + 8'd1;
            end
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares one `uart_tx` transmitter among `NUM_CH` byte-stream requesters. It accepts bytes with a valid/ready handshake and issues single-cycle `tx_start` pulses with latched `tx_data`. It tracks the transmitter through `tx_busy` and enforces a programmable inter-frame gap measured in baud ticks. Packets, marked by `req_last`, are never interleaved: the owner keeps the transmitter until its last byte has been sent.

## Interface
- `NUM_CH`, default 4: number of requesters, 2..8.
- `GAP_TICKS`, default 1: idle `baud_tick_1x` ticks inserted after each frame completes, 0..255.
- `CH_W`, default `$clog2(NUM_CH)`: width of `grant_id`.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `baud_tick_1x`  in  1  baud tick shared with `uart_tx`; one cycle wide.
- `req_valid`  in  `NUM_CH`  per-channel byte valid.
- `req_data`  in  `8*NUM_CH`  channel i byte at `[8i+7:8i]`.
- `req_last`  in  `NUM_CH`  byte is the final byte of its packet.
- `req_ready`  out  `NUM_CH`  one-hot byte accept (combinational).
- `tx_busy`  in  1  from `uart_tx`.
- `tx_start`  out  1  registered one-cycle start pulse to `uart_tx`.
- `tx_data`  out  8  registered byte to `uart_tx`.
- `grant_valid`  out  1  a channel currently owns the transmitter.
- `grant_id`  out  `CH_W`  owning channel.

## Operation
- **FSM states:** IDLE, START, WAIT_BUSY, WAIT_DONE, GAP, HOLD.
- **IDLE**
  - Accept condition: `tx_busy==0` and any `req_valid`.
  - Winner is the first valid channel searching from `rr_ptr` upward, modulo `NUM_CH`.
  - On accept: `req_ready[winner]=1` this cycle; latch `tx_data`, `grant_id` and `last_flag`; set `grant_valid=1`; go to START.
- **HOLD**
  - Only channel `grant_id` is considered. Accept when `req_valid[grant_id]` and `tx_busy==0`, with the same latching as IDLE; go to START.
  - Other channels are ignored indefinitely.
- **START:** `tx_start=1` for exactly this cycle; go to WAIT_BUSY.
- **WAIT_BUSY:** wait for `tx_busy==1`, then go to WAIT_DONE.
- **WAIT_DONE:** wait for `tx_busy==0`, then go to GAP with the gap counter cleared.
- **GAP**
  - Count `baud_tick_1x` pulses. When the count reaches `GAP_TICKS` (immediately if 0), leave GAP.
  - If `last_flag` is set: go to IDLE, set `rr_ptr = grant_id+1` (mod `NUM_CH`), clear `grant_valid`.
  - Otherwise: go to HOLD.
- **Handshake rules:**
  - `req_ready` is asserted only in IDLE or HOLD, only on the accepted channel, and is never asserted unless the matching `req_valid` is set.
  - Requesters must hold data stable while valid and not ready.
- **Simultaneous requests:** resolved solely by `rr_ptr`. After reset `rr_ptr=0`, so channel 0 has the highest priority.
- **Packet boundaries:** a single-byte packet (`req_last=1` on its first byte) releases ownership after its gap.
- **Reset values:** `tx_start=0`, `tx_data=8'h00`, `req_ready=0`, `grant_valid=0`, `grant_id=0`, `rr_ptr=0`, state IDLE, gap counter 0.
- **Reset mid-operation:** everything returns to reset values immediately. No attempt is made to complete an in-flight frame; `uart_tx` resets on the same `rst_n`.

## Timing
- **Accept to start:** accept at cycle T; `tx_start` is high at T+1; `uart_tx` loads at the end of T+1; `tx_busy` rises at T+2.
- **Frame duration:** `tx_busy` stays high for 10 `baud_tick_1x` pulses after load.
- **Gap:** measured in baud ticks starting the cycle after `tx_busy` falls.
- **Minimum accept-to-accept spacing for consecutive bytes:** 10 ticks plus `GAP_TICKS` ticks plus 4 clocks.
- **`tx_start` constraints:**
  - Never asserted while `tx_busy==1`.
  - Never asserted on two consecutive cycles.
- **`tx_data`:** stable from START until the next accept.

## Test plan
- **Single byte:** `NUM_CH=4`, `GAP_TICKS=1`; ch2 sends `8'hA5` with `last=1` -> `req_ready[2]` for 1 cycle, `tx_start` one cycle later with `tx_data=A5`, line carries `0,1,0,1,0,0,1,0,1,1`. Afterwards `grant_valid=0` and `rr_ptr=3`.
- **Round-robin:** ch0, ch1 and ch3 all valid with single-byte packets `11`, `22`, `33` -> transmit order 11, 22, 33; with ch0 re-requesting `44` after its first byte, 44 is sent after 33.
- **Packet lock:** ch1 sends a 3-byte packet `01 02 03` (`last` on 03) while ch0 is continuously valid -> ch0 is not granted until 03 completes plus the gap; then ch0 is granted.
- **Owner stall:** ch1 sends byte 1 of 2, then deasserts valid for 1000 cycles while ch2 is valid -> state stays HOLD, no `tx_start`, `req_ready[2]` stays 0; ch1 later resumes and completes.
- **Gap and back-pressure:** `GAP_TICKS=3`; ch0 sends two bytes -> exactly 3 `baud_tick_1x` pulses between the first `tx_busy` fall and the second `req_ready`.
- **Reset mid-frame:** assert `rst_n=0` during WAIT_DONE of a locked packet -> all outputs at reset values; after release, ch0 wins first arbitration and no stale `tx_start` is issued.
